alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_sequencer_cmd_fifo.sv | 51 +++++
 rtl/alu_sequencer.sv | 111 +++++++++++
 tb/tb_alu_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, status-bit and command definitions for the ALU sequencer.
package alu_pkg;

    localparam int unsigned OPC_W  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CMD_W  = OPC_W + DATA_W + 1;

    localparam logic [OPC_W-1:0] OP_NOP    = 4'h0;
    localparam logic [OPC_W-1:0] OP_LOAD   = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD    = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB    = 4'h3;
    localparam logic [OPC_W-1:0] OP_ZERO   = 4'h4;
    localparam logic [OPC_W-1:0] OP_ONE    = 4'h5;
    localparam logic [OPC_W-1:0] OP_XOR    = 4'h6;
    localparam logic [OPC_W-1:0] OP_STATUS = 4'hF;

    localparam int unsigned ST_ZERO_BIT  = 0;
    localparam int unsigned ST_NEG_BIT   = 1;
    localparam int unsigned ST_CARRY_BIT = 2;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [DATA_W-1:0] data;
        logic              capture;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_RESP    = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_sequencer_cmd_fifo.sv
// Power-of-two command FIFO with registered occupancy and show-ahead read data.
module cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 13,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata_c,
    output logic [LVL_W-1:0] level,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign rdata_c = mem[rd_ptr];
    assign full_c  = (level == LVL_W'(DEPTH));
    assign empty_c = (level == '0);

    // Storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issues queued commands to an external ALU one per cycle and returns captured results.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OPC_W-1:0]  cmd_opcode,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_capture,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic [DATA_W-1:0] alu_data,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              busy
);

    seq_state_t        state, state_d;
    cmd_t              wr_cmd, head;
    logic              push_c, pop_c, full_c, empty_c;
    logic              cap_pend, cap_pend_d;
    logic [OPC_W-1:0]  opcode_d;
    logic [DATA_W-1:0] data_d;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_d;

    assign wr_cmd    = '{opcode: cmd_opcode, data: cmd_data, capture: cmd_capture};
    assign cmd_ready = !full_c;
    assign push_c    = cmd_valid && cmd_ready;
    assign busy      = !empty_c || (state != S_IDLE) || cap_pend;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_c),
        .wdata   (wr_cmd),
        .pop     (pop_c),
        .rdata_c (head),
        .level   (fifo_level),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    // cap_pend marks the cycle a capture op sits on the ALU bus, so CAPTURE
    // lands on the cycle the ALU result of that op is visible.
    always_comb begin
        state_d     = state;
        cap_pend_d  = 1'b0;
        pop_c       = 1'b0;
        opcode_d    = OP_NOP;
        data_d      = '0;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        case (state)
            S_IDLE: begin
                if (cap_pend) begin
                    state_d = S_CAPTURE;
                end else if (!empty_c) begin
                    pop_c = 1'b1;
                end
            end
            S_CAPTURE: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = alu_result;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    pop_c       = !empty_c;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop_c) begin
            opcode_d   = head.opcode;
            data_d     = head.data;
            cap_pend_d = head.capture;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cap_pend   <= 1'b0;
            alu_opcode <= OP_NOP;
            alu_data   <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
        end else begin
            state      <= state_d;
            cap_pend   <= cap_pend_d;
            alu_opcode <= opcode_d;
            alu_data   <= data_d;
            rsp_valid  <= rsp_valid_d;
            rsp_data   <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer driving a small accumulator ALU model.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_opcode;
    logic [7:0]       cmd_data;
    logic             cmd_capture;
    logic [3:0]       alu_opcode;
    logic [7:0]       alu_data;
    logic [7:0]       alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_data;
    logic [LVL_W-1:0] fifo_level;
    logic             busy;

    int errors = 0;
    int checks = 0;

    alu_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_data    (cmd_data),
        .cmd_capture (cmd_capture),
        .alu_opcode  (alu_opcode),
        .alu_data    (alu_data),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .fifo_level  (fifo_level),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accumulator ALU: op latched at the clock edge, result visible the next cycle.
    logic [7:0] acc, status;
    logic       sel;
    logic [8:0] sum9, dif9;
    assign sum9       = {1'b0, acc} + {1'b0, alu_data};
    assign dif9       = {1'b0, acc} - {1'b0, alu_data};
    assign alu_result = sel ? status : acc;

    function automatic logic [7:0] flags(input logic [7:0] r, input logic c);
        logic [7:0] f;
        f = '0;
        f[ST_ZERO_BIT]  = (r == 8'h00);
        f[ST_NEG_BIT]   = r[7];
        f[ST_CARRY_BIT] = c;
        return f;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            status <= '0;
            sel    <= 1'b0;
        end else begin
            sel <= (alu_opcode == OP_STATUS);
            case (alu_opcode)
                OP_LOAD: begin acc <= alu_data;       status <= flags(alu_data, 1'b0); end
                OP_ADD:  begin acc <= sum9[7:0];      status <= flags(sum9[7:0], sum9[8]); end
                OP_SUB:  begin acc <= dif9[7:0];      status <= flags(dif9[7:0], dif9[8]); end
                OP_ZERO: begin acc <= 8'h00;          status <= flags(8'h00, 1'b0); end
                OP_ONE:  begin acc <= 8'h01;          status <= flags(8'h01, 1'b0); end
                OP_XOR:  begin acc <= acc ^ alu_data; status <= flags(acc ^ alu_data, 1'b0); end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] op, input logic [7:0] d, input logic cap);
        cmd_valid   = 1'b1;
        cmd_opcode  = op;
        cmd_data    = d;
        cmd_capture = cap;
        @(negedge clk);
    endtask

    task automatic push_done();
        cmd_valid   = 1'b0;
        cmd_opcode  = '0;
        cmd_data    = '0;
        cmd_capture = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic take_rsp(input string tag, input logic [7:0] exp);
        wait_rsp(tag);
        check({tag, "_data"}, 32'(rsp_data), 32'(exp));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_cleared"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic wait_op(input string tag, input logic [3:0] op, input logic [7:0] d);
        int n = 0;
        while (alu_opcode != op && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_op"}, 32'(alu_opcode), 32'(op));
        check({tag, "_opdata"}, 32'(alu_data), 32'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int accepted;
        int busy_ops;
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        push_done();
        repeat (3) @(negedge clk);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_opcode", 32'(alu_opcode), 32'd0);
        check("rst_data", 32'(alu_data), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);

        // LOAD 0x05 capture: result valid two cycles after the op is presented
        push(OP_LOAD, 8'h05, 1'b1);
        push_done();
        wait_op("load5", OP_LOAD, 8'h05);
        @(negedge clk);
        check("load5_capture_nop", 32'(alu_opcode), 32'd0);
        check("load5_not_yet", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("load5_valid_n2", 32'(rsp_valid), 32'd1);
        check("load5_data", 32'(rsp_data), 32'h05);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("load5_cleared", 32'(rsp_valid), 32'd0);
        check("load5_idle", 32'(busy), 32'd0);

        // Status after add overflow to zero: zero + carry
        push(OP_LOAD, 8'h80, 1'b0);
        push(OP_ADD, 8'h80, 1'b0);
        push(OP_STATUS, 8'h00, 1'b1);
        push_done();
        take_rsp("status_carry", 8'h05);

        // Status after borrow, then accumulator returns once status-select drops
        push(OP_LOAD, 8'h01, 1'b0);
        push(OP_SUB, 8'h02, 1'b0);
        push(OP_STATUS, 8'h00, 1'b1);
        push(OP_ONE, 8'h00, 1'b1);
        push_done();
        take_rsp("status_borrow", 8'h06);
        take_rsp("one_after_status", 8'h01);

        // Fill the FIFO while the response is held
        push(OP_LOAD, 8'h10, 1'b1);
        push_done();
        wait_rsp("hold");
        check("hold_data", 32'(rsp_data), 32'h10);
        accepted = 0;
        busy_ops = 0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid   = 1'b1;
            cmd_opcode  = OP_ADD;
            cmd_data    = 8'(i + 1);
            cmd_capture = 1'b0;
            if (cmd_ready) accepted++;
            if (alu_opcode != OP_NOP) busy_ops++;
            @(negedge clk);
        end
        push_done();
        check("full_accepted", 32'(accepted), 32'd4);
        check("full_level", 32'(fifo_level), 32'd4);
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        check("full_nops", 32'(busy_ops), 32'd0);
        check("full_opcode_now", 32'(alu_opcode), 32'd0);
        check("hold_stable", 32'(rsp_data), 32'h10);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        wait_op("burst1", OP_ADD, 8'h01);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("burst%0d_op", k), 32'(alu_opcode), 32'(OP_ADD));
            check($sformatf("burst%0d_data", k), 32'(alu_data), 32'(k));
        end
        @(negedge clk);
        check("burst_end_nop", 32'(alu_opcode), 32'd0);
        check("burst_end_level", 32'(fifo_level), 32'd0);

        // Reserved opcode forwarded unchanged; ALU treats it as a nop
        push(4'h9, 8'h33, 1'b1);
        push_done();
        wait_op("fwd9", 4'h9, 8'h33);
        take_rsp("fwd9_acc", 8'h1A);

        // Simultaneous push and pop at level 2
        push(OP_LOAD, 8'h00, 1'b1);
        push_done();
        wait_rsp("pp");
        push(OP_ADD, 8'h07, 1'b0);
        push(OP_ADD, 8'h08, 1'b0);
        check("pp_level_before", 32'(fifo_level), 32'd2);
        cmd_opcode = OP_ADD;
        cmd_data   = 8'h09;
        rsp_ready  = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        push_done();
        check("pp_level_after", 32'(fifo_level), 32'd2);
        repeat (6) @(negedge clk);
        check("pp_drained", 32'(fifo_level), 32'd0);
        push(OP_NOP, 8'h00, 1'b1);
        push_done();
        take_rsp("pp_acc", 8'h18);

        // Reset while holding a response with commands queued
        push(OP_LOAD, 8'h44, 1'b1);
        push_done();
        wait_rsp("rstresp");
        push(OP_ADD, 8'h01, 1'b0);
        push(OP_ADD, 8'h02, 1'b0);
        push_done();
        check("rstresp_level_before", 32'(fifo_level), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstresp_valid", 32'(rsp_valid), 32'd0);
        check("rstresp_level", 32'(fifo_level), 32'd0);
        check("rstresp_ready", 32'(cmd_ready), 32'd1);
        check("rstresp_data", 32'(rsp_data), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rstresp_busy", 32'(busy), 32'd0);
        check("rstresp_no_rsp", 32'(rsp_valid), 32'd0);
        check("rstresp_opcode", 32'(alu_opcode), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
